// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a requester and the PS/2 host transmitter.
//   tx_valid / tx_data : command byte offered by the requester
//   tx_ready           : transmitter idle and able to accept a byte
//   tx_done / tx_error : one-cycle completion / failure pulses
//   tx_busy            : inverse of tx_ready, lets the receive path ignore its own traffic
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       tx_busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_error, tx_busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_error, tx_busy
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to a keyboard.
// The host inhibits the clock, asserts the start bit, then shifts data, odd
// parity and stop on device-generated falling clock edges and checks the ACK.
// Ports:
//   clock, reset              : system clock, synchronous active-high reset
//   tx (ps2_host_tx_if.slave) : command handshake, done/error pulses, busy
//   ps2_clk_in, ps2_data_in   : raw (asynchronous) PS/2 lines
//   ps2_clk_oe, ps2_data_oe   : open-collector pull-low enables for the lines
// Optional feature: define PS2_TX_TIMEOUT_EN to abort a transfer that has not
// reached WAIT_IDLE within TIMEOUT_CYCLES cycles of entering REQ.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic                 clock,
  input  logic                 reset,
  ps2_host_tx_if.slave         tx,
  input  logic                 ps2_clk_in,
  input  logic                 ps2_data_in,
  output logic                 ps2_clk_oe,
  output logic                 ps2_data_oe
);

  localparam int unsigned InhW   = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned EdgeW  = 4;
  localparam int unsigned FrameW = 10;
  localparam int unsigned LastEdgeIdx = FrameW - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e              state_q,    state_d;
  logic                clk_meta_q, clk_meta_d;
  logic                clk_sync_q, clk_sync_d;
  logic                clk_prev_q, clk_prev_d;
  logic                dat_meta_q, dat_meta_d;
  logic                dat_sync_q, dat_sync_d;
  logic [FrameW-1:0]   frame_q,    frame_d;
  logic [EdgeW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [InhW-1:0]     inh_cnt_q,  inh_cnt_d;
  logic                clk_oe_q,   clk_oe_d;
  logic                data_oe_q,  data_oe_d;
  logic                ready_q,    ready_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                error_q,    error_d;
  logic                fall_c;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0]      to_cnt_q,   to_cnt_d;
`else
  // The timeout limit has no effect when the watchdog is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Two-flop synchronizers plus one history flop for clock edge detection.
  assign clk_meta_d = ps2_clk_in;
  assign clk_sync_d = clk_meta_q;
  assign clk_prev_d = clk_sync_q;
  assign dat_meta_d = ps2_data_in;
  assign dat_sync_d = dat_meta_q;
  assign fall_c     = clk_prev_q & ~clk_sync_q;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    edge_cnt_d = edge_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_d   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        edge_cnt_d = '0;
        inh_cnt_d  = '0;
        if (tx.tx_valid && ready_q) begin
          // Frame shifted LSB first: d0..d7, odd parity, stop.
          frame_d = {1'b1, ~^tx.tx_data, tx.tx_data};
          state_d = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q != InhW'(INHIBIT_CYCLES)) begin
          inh_cnt_d = inh_cnt_q + InhW'(1);
        end
        if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        state_d = S_SEND;
      end

      S_SEND: begin
        if (fall_c) begin
          // Pull the line low for a 0 bit; the stop bit releases it.
          data_oe_d = ~frame_q[edge_cnt_q];
          if (edge_cnt_q != EdgeW'(FrameW)) begin
            edge_cnt_d = edge_cnt_q + EdgeW'(1);
          end
          if (edge_cnt_q == EdgeW'(LastEdgeIdx)) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (fall_c) begin
          if (!dat_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog from REQ entry; an expiry overrides any ACK outcome this cycle.
    if (state_q inside {S_REQ, S_SEND, S_ACK}) begin
      if (to_cnt_q != ToW'(TIMEOUT_CYCLES)) begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
      if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
    end
`endif

    // Line drive follows the state being entered so outputs stay registered.
    if (state_d == S_IDLE || state_d == S_INHIBIT) begin
      data_oe_d = 1'b0;
    end else if (state_d == S_REQ) begin
      data_oe_d = 1'b1;
    end
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
    ready_d  = (state_d == S_IDLE);
    busy_d   = ~ready_d;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      frame_q    <= '0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      frame_q    <= frame_d;
      edge_cnt_q <= edge_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.tx_busy  = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks frames, a scoreboard holds
// expected per-edge data_oe values and expected done/error outcomes.
module tb_ps2_host_tx;
  localparam int unsigned INH  = 5000;
  localparam int unsigned TMO  = 100;
  localparam int          HALF = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Main DUT with a keyboard model on the lines.
  ps2_host_tx_if tx_if ();
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(750000)) dut (
    .clock(clock), .reset(reset), .tx(tx_if),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  // Second DUT with a silent device, short timeout.
  ps2_host_tx_if tx2 ();
  logic clk_oe2, data_oe2, clk_line2, data_line2;
  assign clk_line2  = ~clk_oe2;
  assign data_line2 = ~data_oe2;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut2 (
    .clock(clock), .reset(reset), .tx(tx2),
    .ps2_clk_in(clk_line2), .ps2_data_in(data_line2),
    .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int hs_cnt   = 0;
  int p2_cnt   = 0;
  bit chk_ready_next = 1'b0;

  bit         exp_oe_q[$];
  logic [1:0] exp_res_q[$];   // {error, done}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clock) begin
    if (tx_if.tx_valid && tx_if.tx_ready) hs_cnt++;
    if (tx2.tx_done || tx2.tx_error) p2_cnt++;
  end

  // Result scoreboard: every pulse must match the oldest expected outcome.
  always @(negedge clock) begin
    if (chk_ready_next) begin
      check("ready_after_error", tx_if.tx_ready, 1);
      chk_ready_next = 1'b0;
    end
    if (tx_if.tx_done || tx_if.tx_error) begin
      if (tx_if.tx_done) done_cnt++;
      if (tx_if.tx_error) err_cnt++;
      check("pulse_exclusive", tx_if.tx_done & tx_if.tx_error, 0);
      if (exp_res_q.size() == 0)
        check("unexpected_pulse", {tx_if.tx_error, tx_if.tx_done}, 0);
      else
        check("result", {tx_if.tx_error, tx_if.tx_done}, exp_res_q.pop_front());
      if (tx_if.tx_error) chk_ready_next = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_oe_q.push_back(~d[i]);
    exp_oe_q.push_back(~(~^d));
    exp_oe_q.push_back(1'b0);
  endtask

  task automatic start_tx(input logic [7:0] d);
    int w = 0;
    while (!tx_if.tx_ready && w < 1000) begin @(negedge clock); w++; end
    check("start_ready", tx_if.tx_ready, 1);
    push_frame(d);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    @(negedge clock);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic check_inhibit(input string tag);
    int cnt = 0;
    while (ps2_clk_oe && !ps2_data_oe && cnt < int'(INH) + 10) begin
      cnt++;
      @(negedge clock);
    end
    check({tag, "_len"}, cnt, INH);
    check({tag, "_req"}, {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clock);
    check({tag, "_send"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  // Keyboard model: n falling edges, optional ACK on edge 11.
  task automatic device(input int n_edges, input bit ack);
    int w = 0;
    while (!(tx_if.tx_busy && !ps2_clk_oe) && w < 20000) begin @(negedge clock); w++; end
    check("dev_start", w < 20000, 1);
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk_low = 1'b0;
      if (e == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clock);
      dev_clk_low = 1'b1;
      repeat (HALF / 2) @(negedge clock);
      if (e <= 10) begin
        check("oe_queue_nonempty", exp_oe_q.size() != 0, 1);
        if (exp_oe_q.size() != 0)
          check($sformatf("data_oe_edge%0d", e), ps2_data_oe, exp_oe_q.pop_front());
      end
      repeat (HALF - HALF / 2) @(negedge clock);
    end
    dev_clk_low = 1'b0;
    repeat (4) @(negedge clock);
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  initial begin
    int d0, e0, h0, cnt;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx2.tx_valid   = 1'b0;
    tx2.tx_data    = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.tx_busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_pulses", {tx_if.tx_done, tx_if.tx_error}, 2'b00);
    reset = 1'b0;
    @(negedge clock);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    exp_res_q.push_back(2'b01);
    start_tx(8'hED);
    check("ed_busy", {tx_if.tx_busy, tx_if.tx_ready}, 2'b10);
    check_inhibit("ed_inh");
    device(11, 1'b1);
    check("ed_done_cnt", done_cnt - d0, 1);
    check("ed_err_cnt", err_cnt - e0, 0);
    check("ed_idle", {tx_if.tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

    // 0x00: parity bit 1
    d0 = done_cnt; e0 = err_cnt;
    exp_res_q.push_back(2'b01);
    start_tx(8'h00);
    check_inhibit("z_inh");
    device(11, 1'b1);
    check("z_done_cnt", done_cnt - d0, 1);
    check("z_err_cnt", err_cnt - e0, 0);

    // NACK
    d0 = done_cnt; e0 = err_cnt;
    exp_res_q.push_back(2'b10);
    start_tx(8'h5A);
    check_inhibit("nack_inh");
    device(11, 1'b0);
    check("nack_err_cnt", err_cnt - e0, 1);
    check("nack_done_cnt", done_cnt - d0, 0);
    check("nack_ready", tx_if.tx_ready, 1);

    // Silent device on the second instance
    tx2.tx_valid = 1'b1;
    tx2.tx_data  = 8'h12;
    @(negedge clock);
    tx2.tx_valid = 1'b0;
    cnt = 0;
    while (!(clk_oe2 && data_oe2) && cnt < int'(INH) + 10) begin @(negedge clock); cnt++; end
    check("to_req_seen", {clk_oe2, data_oe2}, 2'b11);
`ifdef PS2_TX_TIMEOUT_EN
    cnt = 0;
    while (!tx2.tx_error && cnt < int'(TMO) + 50) begin @(negedge clock); cnt++; end
    check("to_latency", cnt, TMO);
    check("to_oe", {clk_oe2, data_oe2}, 2'b00);
    check("to_no_done", tx2.tx_done, 0);
    @(negedge clock);
    check("to_ready", {tx2.tx_ready, tx2.tx_error}, 2'b10);
`else
    repeat (10000) @(negedge clock);
    check("nto_send", {tx2.tx_busy, clk_oe2, data_oe2}, 3'b101);
    check("nto_no_pulse", p2_cnt, 0);
`endif

    // Reset after edge 5, then a clean 0xF4
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h2C);
    check_inhibit("rst_inh");
    device(5, 1'b0);
    check("rst_pre_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_mid_ready", tx_if.tx_ready, 1);
    reset = 1'b0;
    exp_oe_q.delete();
    repeat (50) @(negedge clock);
    check("rst_mid_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    exp_res_q.push_back(2'b01);
    start_tx(8'hF4);
    check_inhibit("f4_inh");
    device(11, 1'b1);
    check("f4_done_cnt", done_cnt - d0, 1);

    // tx_valid held high, tx_data changed mid-frame
    d0 = done_cnt; h0 = hs_cnt;
    exp_res_q.push_back(2'b01);
    exp_res_q.push_back(2'b01);
    push_frame(8'hA5);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hA5;
    @(negedge clock);
    check_inhibit("hold_inh");
    tx_if.tx_data = 8'h3C;
    check("hold_hs_one", hs_cnt - h0, 1);
    device(11, 1'b1);
    check("hold_hs_two", hs_cnt - h0, 2);
    tx_if.tx_valid = 1'b0;
    check("hold_busy2", tx_if.tx_busy, 1);
    push_frame(8'h3C);
    device(11, 1'b1);
    check("hold_done_cnt", done_cnt - d0, 2);

    repeat (20) @(negedge clock);
    check("res_queue_empty", exp_res_q.size(), 0);
    check("oe_queue_empty", exp_oe_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
